redmule_x_loader: RTL and testbench
===================================

Name: redmule_x_loader

Overview:
- Upstream feeder of the X operand buffer.
- Accepts DW-wide X words from the streamer over a valid/ready handshake and holds them in a small FIFO.
- Issues single-cycle load strobes with data towards the X buffer, counting loads per block (rows × depth slots).
- Sequences a programmed number of blocks, waiting for the X buffer to report empty between blocks.

Parameters:
DW, 288, streamer/X-buffer word width in bits
BITW, 16, element width in bits
H, 4, array height (elements per row group per load)
W, 12, array width (rows per block)
D, DW/(H*BITW), depth slots per block (localparam, 4 with defaults)
FIFO_DEPTH, 2, input FIFO entries (power of two, >=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
clear_i  in  1  synchronous flush
start_i  in  1  start pulse; config latched on this cycle when IDLE
cfg_rows_i  in  $clog2(W)+1  valid rows per block; 0 means W
cfg_slots_i  in  $clog2(D)+1  valid depth slots per block; 0 means D
cfg_blocks_i  in  16  number of blocks to load
stream_valid_i  in  1  streamer data valid
stream_ready_o  out  1  loader accepts streamer data
stream_data_i  in  DW  streamer data
load_o  out  1  load strobe to X buffer
data_o  out  DW  data accompanying load_o (FIFO head)
xbuf_empty_i  in  1  X buffer empty flag
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse after last block consumed
load_cnt_o  out  $clog2(W*D)+1  loads issued in current block

Behaviour:
- Reset: state IDLE, FIFO empty, all counters 0; stream_ready_o=0, load_o=0, data_o=0, busy_o=0, done_o=0, load_cnt_o=0.
- Loads per block: LPB = ceil(rows/H) * slots, where rows/slots are after 0-substitution. Computed once at start and registered.
- States:
  - IDLE: start_i with cfg_blocks_i!=0 -> FILL; latch config; blocks_left=cfg_blocks_i.
  - IDLE: start_i with cfg_blocks_i==0 -> done_o pulses the next cycle, state stays IDLE.
  - FILL: load_o = FIFO not empty. Each load pops one entry and increments load_cnt_o. On the load where load_cnt_o==LPB-1 -> WAIT_EMPTY; load_cnt_o cleared; blocks_left decremented.
  - WAIT_EMPTY: no loads issued; FIFO may still accept data (prefetch). xbuf_empty_i=1 -> FILL if blocks_left!=0, else IDLE with done_o=1 for one cycle.
- FIFO:
  - stream_ready_o = (state!=IDLE) && !fifo_full. There is no pass-through; a push on a full FIFO never happens.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - data_o is the registered head entry. A word accepted in cycle t can appear with load_o in cycle t+1 at the earliest.
  - data_o holds its value while load_o=0 and is 0 when the FIFO is empty.
- xbuf_empty_i is sampled only in WAIT_EMPTY and ignored elsewhere.
- start_i is ignored when not IDLE.
- clear_i has priority over every other event, including start_i and a simultaneous load:
  - flushes the FIFO, zeroes counters, forces IDLE;
  - no done_o pulse.
- rst_ni assertion mid-block returns all state to reset values immediately; the streamer must be restarted by the controller.
- Counter widths hold W*D and 2^16-1 without wrap. blocks_left never underflows because decrement happens only in FILL, and FILL is entered only with blocks_left!=0.

Test Plan:
- Default params, start with rows=0, slots=0, blocks=1; stream 12 words back-to-back -> exactly 12 load_o pulses carrying the data in order; WAIT_EMPTY entered; pulse xbuf_empty_i -> done_o one cycle later, busy_o low.
- rows=5, slots=3, blocks=2 -> LPB=6; 12 loads total; no load_o between block 1's 6th load and xbuf_empty_i; FIFO prefetches 2 words during WAIT_EMPTY (stream_ready_o drops when full).
- Random stream_valid_i gaps with FIFO full/empty crossings -> no data loss or duplication; stream_ready_o never high while full; simultaneous push/pop keeps count constant.
- blocks=0 start -> no load_o, done_o pulses next cycle; start_i asserted during FILL -> ignored, counts unchanged.
- clear_i asserted mid-block with FIFO holding 2 words -> next cycle IDLE, FIFO empty, load_cnt_o=0, data_o=0, no done_o.
- Async rst_ni low during WAIT_EMPTY -> outputs reach reset values without a clock edge; a new start afterwards runs a full block correctly.

Source files
------------

// File: rtl/redmule_x_loader.sv
// X-operand loader: buffers streamer words in a small FIFO and issues load strobes
// to the X buffer, one block of ceil(rows/H)*slots loads at a time.
//
// state      | meaning
// S_IDLE     | waiting for start_i; FIFO closed to the streamer
// S_FILL     | issuing one load per cycle while the FIFO has data
// S_WAIT     | block complete; FIFO may prefetch, waiting for xbuf_empty_i
module redmule_x_loader #(
    parameter int unsigned DW         = 288,
    parameter int unsigned BITW       = 16,
    parameter int unsigned H          = 4,
    parameter int unsigned W          = 12,
    parameter int unsigned FIFO_DEPTH = 2,
    localparam int unsigned D         = DW / (H * BITW),
    localparam int unsigned RW        = $clog2(W) + 1,
    localparam int unsigned SW        = $clog2(D) + 1,
    localparam int unsigned CW        = $clog2(W * D) + 1,
    localparam int unsigned AW        = $clog2(FIFO_DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          start_i,
    input  logic [RW-1:0] cfg_rows_i,
    input  logic [SW-1:0] cfg_slots_i,
    input  logic [15:0]   cfg_blocks_i,
    input  logic          stream_valid_i,
    output logic          stream_ready_o,
    input  logic [DW-1:0] stream_data_i,
    output logic          load_o,
    output logic [DW-1:0] data_o,
    input  logic          xbuf_empty_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [CW-1:0] load_cnt_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_load_cnt;
    logic [CW-1:0] r_lpb;
    logic [15:0]   r_blocks_left;
    logic          r_done;

    logic [DW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic [RW-1:0] w_rows_eff;
    logic [SW-1:0] w_slots_eff;
    logic [CW-1:0] w_lpb;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_last;

    // Zero in either config field selects the full array dimension.
    assign w_rows_eff  = (cfg_rows_i == '0) ? RW'(W) : cfg_rows_i;
    assign w_slots_eff = (cfg_slots_i == '0) ? SW'(D) : cfg_slots_i;
    assign w_lpb       = CW'(((32'(w_rows_eff) + H - 1) / H) * 32'(w_slots_eff));

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW + 1)'(FIFO_DEPTH));

    // clear_i masks both handshakes so nothing is accepted or consumed while flushing.
    assign stream_ready_o = (r_state != S_IDLE) && !w_full && !clear_i;
    assign load_o         = (r_state == S_FILL) && !w_empty && !clear_i;

    assign w_push = stream_valid_i && stream_ready_o;
    assign w_pop  = load_o;
    assign w_last = w_pop && (r_load_cnt == r_lpb - CW'(1));

    assign data_o     = w_empty ? '0 : r_mem[r_rptr];
    assign busy_o     = (r_state != S_IDLE);
    assign done_o     = r_done;
    assign load_cnt_o = r_load_cnt;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= stream_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (clear_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= S_IDLE;
            r_load_cnt    <= '0;
            r_lpb         <= '0;
            r_blocks_left <= '0;
            r_done        <= 1'b0;
        end else if (clear_i) begin
            r_state       <= S_IDLE;
            r_load_cnt    <= '0;
            r_lpb         <= '0;
            r_blocks_left <= '0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (cfg_blocks_i != '0) begin
                            r_state       <= S_FILL;
                            r_lpb         <= w_lpb;
                            r_blocks_left <= cfg_blocks_i;
                            r_load_cnt    <= '0;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (w_last) begin
                        r_load_cnt    <= '0;
                        r_blocks_left <= r_blocks_left - 16'd1;
                        r_state       <= S_WAIT;
                    end else if (w_pop) begin
                        r_load_cnt <= r_load_cnt + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (xbuf_empty_i) begin
                        if (r_blocks_left != '0) begin
                            r_state <= S_FILL;
                        end else begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_redmule_x_loader.sv
// Directed bench for redmule_x_loader: table of block configurations plus
// hand-written sequences for start-while-busy, blocks=0, clear and async reset.
module tb_redmule_x_loader;

    localparam int DW = 288;
    localparam int W  = 12;
    localparam int D  = 4;
    localparam int FIFO_DEPTH = 2;
    localparam int RW = $clog2(W) + 1;
    localparam int SW = $clog2(D) + 1;
    localparam int CW = $clog2(W * D) + 1;

    logic          clk_i;
    logic          rst_ni;
    logic          clear_i;
    logic          start_i;
    logic [RW-1:0] cfg_rows_i;
    logic [SW-1:0] cfg_slots_i;
    logic [15:0]   cfg_blocks_i;
    logic          stream_valid_i;
    logic          stream_ready_o;
    logic [DW-1:0] stream_data_i;
    logic          load_o;
    logic [DW-1:0] data_o;
    logic          xbuf_empty_i;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] load_cnt_o;

    redmule_x_loader dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .start_i        (start_i),
        .cfg_rows_i     (cfg_rows_i),
        .cfg_slots_i    (cfg_slots_i),
        .cfg_blocks_i   (cfg_blocks_i),
        .stream_valid_i (stream_valid_i),
        .stream_ready_o (stream_ready_o),
        .stream_data_i  (stream_data_i),
        .load_o         (load_o),
        .data_o         (data_o),
        .xbuf_empty_i   (xbuf_empty_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .load_cnt_o     (load_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [RW-1:0] rows;
        logic [SW-1:0] slots;
        logic [15:0]   blocks;
        int            lpb;
        bit            gaps;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    bit  bench_busy = 0;
    bit  bench_fill = 0;
    bit  done_exp   = 0;
    bit  gaps       = 0;
    int  blk_loads  = 0;
    int  blk_ends   = 0;
    int  cur_lpb    = 1;
    int  job_total  = 0;
    int  job_pushes = 0;
    int  word_idx   = 0;

    function automatic logic [DW-1:0] mk_word(input int k);
        logic [31:0] t;
        t = 32'h5A00_0000 ^ 32'(k);
        return {(DW / 32){t}};
    endfunction

    function automatic void chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // One cycle: compare outputs against the model, advance the model, step to next negedge.
    task automatic tick();
        logic [DW-1:0] exp_head;
        bit exp_load, exp_ready;
        #1;
        exp_head  = (q.size() != 0) ? q[0] : '0;
        exp_load  = bench_fill && (q.size() != 0) && !clear_i;
        exp_ready = bench_busy && (q.size() < FIFO_DEPTH) && !clear_i;
        chk("data_o", data_o, exp_head);
        chk("load_o", DW'(load_o), DW'(exp_load));
        chk("stream_ready_o", DW'(stream_ready_o), DW'(exp_ready));
        chk("busy_o", DW'(busy_o), DW'(bench_busy));
        chk("load_cnt_o", DW'(load_cnt_o), DW'(blk_loads));
        chk("done_o", DW'(done_o), DW'(done_exp));
        done_exp = 0;
        if (clear_i) begin
            q.delete();
            blk_loads  = 0;
            bench_fill = 0;
            bench_busy = 0;
            job_total  = job_pushes;
        end else begin
            if (exp_load) begin
                void'(q.pop_front());
                blk_loads++;
                if (blk_loads == cur_lpb) begin
                    blk_loads  = 0;
                    bench_fill = 0;
                    blk_ends++;
                end
            end
            if (stream_valid_i && exp_ready) begin
                q.push_back(stream_data_i);
                job_pushes++;
                word_idx++;
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
        stream_data_i  = mk_word(word_idx);
        stream_valid_i = (job_pushes < job_total) && (!gaps || $urandom_range(0, 2) != 0);
    endtask

    task automatic start_job(input logic [RW-1:0] r, input logic [SW-1:0] s,
                             input logic [15:0] b, input int lpb);
        cfg_rows_i   = r;
        cfg_slots_i  = s;
        cfg_blocks_i = b;
        start_i      = 1'b1;
        tick();
        start_i    = 1'b0;
        cur_lpb    = lpb;
        job_pushes = 0;
        job_total  = lpb * int'(b);
        if (b != 16'd0) begin
            bench_busy = 1;
            bench_fill = 1;
        end else begin
            done_exp = 1;
        end
        stream_valid_i = (job_pushes < job_total);
    endtask

    task automatic fill_block();
        int e;
        e = blk_ends;
        for (int i = 0; i < 300 && blk_ends == e; i++) tick();
        chk("block_end_reached", DW'(blk_ends - e), DW'(1));
    endtask

    // Hold WAIT_EMPTY for a while (loads must stay off, FIFO may prefetch), then release.
    task automatic wait_block(input int hold, input bit last);
        for (int i = 0; i < hold; i++) tick();
        xbuf_empty_i = 1'b1;
        tick();
        xbuf_empty_i = 1'b0;
        if (last) begin
            bench_busy = 0;
            done_exp   = 1;
        end else begin
            bench_fill = 1;
        end
    endtask

    task automatic run_job(input logic [RW-1:0] r, input logic [SW-1:0] s,
                           input logic [15:0] b, input int lpb);
        start_job(r, s, b, lpb);
        for (int k = 0; k < int'(b); k++) begin
            fill_block();
            wait_block(6, k == int'(b) - 1);
        end
        tick();
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{rows: 5'd0,  slots: 3'd0, blocks: 16'd1, lpb: 12, gaps: 1'b0};
        vecs[1] = '{rows: 5'd5,  slots: 3'd3, blocks: 16'd2, lpb: 6,  gaps: 1'b0};
        vecs[2] = '{rows: 5'd1,  slots: 3'd1, blocks: 16'd3, lpb: 1,  gaps: 1'b0};
        vecs[3] = '{rows: 5'd4,  slots: 3'd4, blocks: 16'd1, lpb: 4,  gaps: 1'b1};
        vecs[4] = '{rows: 5'd9,  slots: 3'd2, blocks: 16'd2, lpb: 6,  gaps: 1'b1};
        vecs[5] = '{rows: 5'd3,  slots: 3'd0, blocks: 16'd1, lpb: 4,  gaps: 1'b0};
        vecs[6] = '{rows: 5'd0,  slots: 3'd1, blocks: 16'd2, lpb: 3,  gaps: 1'b1};
        vecs[7] = '{rows: 5'd12, slots: 3'd3, blocks: 16'd1, lpb: 9,  gaps: 1'b0};

        rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; xbuf_empty_i = 1'b0;
        cfg_rows_i = '0; cfg_slots_i = '0; cfg_blocks_i = '0;
        stream_valid_i = 1'b0; stream_data_i = '0;
        repeat (2) @(negedge clk_i);
        chk("reset_ready", DW'(stream_ready_o), '0);
        chk("reset_load", DW'(load_o), '0);
        chk("reset_data", data_o, '0);
        chk("reset_busy", DW'(busy_o), '0);
        chk("reset_done", DW'(done_o), '0);
        chk("reset_cnt", DW'(load_cnt_o), '0);
        rst_ni = 1'b1;
        tick();

        for (int v = 0; v < 8; v++) begin
            gaps = vecs[v].gaps;
            run_job(vecs[v].rows, vecs[v].slots, vecs[v].blocks, vecs[v].lpb);
        end
        gaps = 0;

        // blocks=0: immediate done, nothing loaded
        start_job(5'd0, 3'd0, 16'd0, 12);
        tick();
        tick();

        // start_i mid-block with a different config is ignored
        start_job(5'd5, 3'd3, 16'd1, 6);
        for (int i = 0; i < 300 && blk_loads < 3; i++) tick();
        cfg_rows_i = 5'd1; cfg_slots_i = 3'd1; cfg_blocks_i = 16'd7;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        fill_block();
        wait_block(3, 1);
        tick();

        // clear_i on the first FILL cycle of block 2 with two prefetched words held
        start_job(5'd5, 3'd3, 16'd2, 6);
        fill_block();
        wait_block(4, 0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("clear_data", data_o, '0);
        chk("clear_cnt", DW'(load_cnt_o), '0);
        chk("clear_busy", DW'(busy_o), '0);
        repeat (3) tick();

        // async reset while waiting in WAIT_EMPTY with a full FIFO
        start_job(5'd5, 3'd3, 16'd2, 6);
        fill_block();
        repeat (4) tick();
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_ready", DW'(stream_ready_o), '0);
        chk("arst_load", DW'(load_o), '0);
        chk("arst_data", data_o, '0);
        chk("arst_busy", DW'(busy_o), '0);
        chk("arst_done", DW'(done_o), '0);
        chk("arst_cnt", DW'(load_cnt_o), '0);
        q.delete();
        bench_busy = 0; bench_fill = 0; blk_loads = 0;
        job_total = job_pushes;
        stream_valid_i = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        run_job(5'd0, 3'd0, 16'd1, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

endmodule
